regfile_write_sequencer: RTL and testbench
==========================================

# regfile_write_sequencer

Write-side sequencer for the 16 x 32-bit register file. It accepts destination-register writes from the execute and memory stages through a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drains one write per cycle onto the register file write port (C, PC, ENABLE). While writes are pending, it forwards their data to the two read-address ports A and B so that readers never see stale register contents.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- DATA_W, 32: data width; matches the register file.

- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- WR_VALID  in  1  write request present.
- WR_READY  out  1  = (COUNT < DEPTH); does not depend on a same-cycle drain.
- WR_ADDR  in  4  destination register number.
- WR_DATA  in  DATA_W  write data.
- STALL  in  1  inhibits draining; pushes are still accepted.
- FLUSH  in  1  discards all pending FIFO entries.
- C  out  4  register file write address (registered).
- PC  out  DATA_W  register file write data (registered).
- ENABLE  out  1  register file write enable (registered).
- A, B  in  4  register file read addresses currently in use.
- FWD_A_HIT, FWD_B_HIT  out  1  a pending write targets A / B.
- FWD_A_DATA, FWD_B_DATA  out  DATA_W  forwarded data; 0 when the matching HIT is 0.
- COUNT  out  log2(DEPTH)+1  FIFO occupancy; excludes the output register.
- EMPTY  out  1  = (COUNT == 0) and ENABLE low.

## Operation
- **Push:** WR_VALID & WR_READY at an edge writes {WR_ADDR, WR_DATA} at the tail. The tail pointer wraps modulo DEPTH.
- **Pop:** at an edge with COUNT > 0, STALL = 0 and FLUSH = 0:
  - the head entry loads C/PC;
  - ENABLE is set to 1;
  - the head pointer advances with wrap.
- **No pop:** otherwise ENABLE is set to 0, and C/PC hold their previous values.
- **Simultaneous push and pop:** COUNT unchanged. A push into an empty FIFO cannot pop in the same edge.
- **FLUSH** (synchronous) takes priority over push and pop at that edge:
  - head and tail pointers reset and COUNT becomes 0;
  - ENABLE is set to 0;
  - a push presented in the same cycle is dropped;
  - a write already driven on ENABLE during the FLUSH cycle is not retracted.
- **Forwarding** is combinational from A, B and the current state. The pending set is the valid FIFO entries plus the output register when ENABLE = 1.
  - Match priority is youngest first: tail-1 down to head, then the output register.
  - A and B are evaluated independently; both may hit the same entry.
  - An incoming WR_* that has not yet been accepted is not forwarded.
- **Register 0** is not special; writes to it are sequenced like any other.
- **Order:** writes drain in acceptance order, so the last write to a register wins.

## Timing
- **Reset** (RESET low, asynchronous): pointers 0, COUNT 0, C 0, PC 0, ENABLE 0.
  - Resulting combinational outputs: WR_READY 1, EMPTY 1, both HITs 0, FWD data 0.
  - Reset asserted mid-drain clears all pending writes immediately; ENABLE drops without waiting for an edge.
- **Latency:** a write accepted at edge t with an empty FIFO and STALL low pops at edge t+1. ENABLE is then high from t+1 until t+2, so the write reaches the register file one cycle after acceptance.
- **Throughput:** one write per cycle sustained; the FIFO never fills when STALL stays low.
- **Stall:** each stalled cycle adds one cycle of latency. ENABLE is low for every cycle that follows a stalled edge.
- **Full:** WR_READY is low only while COUNT == DEPTH. It returns high in the cycle after the first pop.
- **Forwarding timing:** HIT/data are valid in the same cycle as A/B, from the entry's acceptance edge until the edge after its ENABLE cycle.

## Test plan
- **Reset:** drive RESET low mid-stream with 3 entries pending -> COUNT 0, ENABLE 0, EMPTY 1, WR_READY 1 immediately, with no clock edge.
- **Single write:** push {R5, 0xDEADBEEF} at edge 0 -> C=5, PC=0xDEADBEEF, ENABLE=1 only during edge1–edge2; COUNT back to 0 after edge 1.
- **Fill under stall:**
  - hold STALL high and push R1..R4 -> COUNT 4, WR_READY 0, a fifth push is ignored;
  - release STALL -> ENABLE high for 4 consecutive cycles with C = 1, 2, 3, 4 in order;
  - WR_READY returns 1 after the first pop.
- **Forwarding priority:**
  - push {R7, 0x11}, then {R7, 0x22}, with STALL high; set A=7, B=7 -> both HITs 1, data 0x22;
  - after the first pop, with STALL released, the data is still 0x22;
  - with A=8 -> FWD_A_HIT 0, FWD_A_DATA 0.
- **Flush with push:** 2 entries pending, FLUSH and a WR_VALID push in the same cycle -> COUNT 0 and ENABLE 0 after the edge; the pushed write never appears on C/PC.
- **Wrap-around:** 10 back-to-back pushes with STALL toggling every other cycle -> all 10 writes appear on C/PC exactly once, in order, with no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/regfile_write_sequencer.sv
// Write-side sequencer for the 16 x 32-bit register file: buffers destination
// writes in a small FIFO, drains one per cycle, and forwards pending data to readers.
module regfile_write_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [3:0]        c,
  output logic [DATA_W-1:0] pc,
  output logic              enable,
  input  logic [3:0]        a,
  input  logic [3:0]        b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit,
  output logic [DATA_W-1:0] fwd_a_data,
  output logic [DATA_W-1:0] fwd_b_data,
  output logic [$clog2(DEPTH):0] count,
  output logic              empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [3:0]        addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  wr_entry_t     mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] fwd_idx;
  logic          push_c;
  logic          pop_c;

  assign wr_ready = (count < CW'(DEPTH));
  assign empty    = (count == '0) && !enable;
  assign push_c   = wr_valid && wr_ready && !flush;
  assign pop_c    = (count != '0) && !stall && !flush;

  // Storage needs no reset: only entries inside [head, head+count) are ever observed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[tail] <= wr_entry_t'({wr_addr, wr_data});
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      c      <= '0;
      pc     <= '0;
      enable <= 1'b0;
    end else if (flush) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      enable <= 1'b0;
    end else begin
      enable <= pop_c;
      if (push_c) begin
        tail <= tail + AW'(1);
      end
      if (pop_c) begin
        head <= head + AW'(1);
        c    <= mem[head].addr;
        pc   <= mem[head].data;
      end
      if (push_c && !pop_c) begin
        count <= count + CW'(1);
      end else if (!push_c && pop_c) begin
        count <= count - CW'(1);
      end
    end
  end

  // Oldest candidate first so younger matches overwrite: output reg, then head..tail-1.
  always_comb begin
    fwd_a_hit  = 1'b0;
    fwd_b_hit  = 1'b0;
    fwd_a_data = '0;
    fwd_b_data = '0;
    fwd_idx    = '0;
    if (enable && (c == a)) begin
      fwd_a_hit  = 1'b1;
      fwd_a_data = pc;
    end
    if (enable && (c == b)) begin
      fwd_b_hit  = 1'b1;
      fwd_b_data = pc;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_idx = head + AW'(i);
      if (CW'(i) < count) begin
        if (mem[fwd_idx].addr == a) begin
          fwd_a_hit  = 1'b1;
          fwd_a_data = mem[fwd_idx].data;
        end
        if (mem[fwd_idx].addr == b) begin
          fwd_b_hit  = 1'b1;
          fwd_b_data = mem[fwd_idx].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Directed self-checking bench for regfile_write_sequencer.
module tb_regfile_write_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        stall;
  logic        flush;
  logic [3:0]  c;
  logic [31:0] pc;
  logic        enable;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_a_data;
  logic [31:0] fwd_b_data;
  logic [2:0]  count;
  logic        empty;

  int n_chk = 0;
  int n_bad = 0;

  regfile_write_sequencer #(.DEPTH(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .stall(stall), .flush(flush),
    .c(c), .pc(pc), .enable(enable),
    .a(a), .b(b),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit),
    .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] ad, input logic [31:0] dt);
    wr_valid = 1'b1;
    wr_addr  = ad;
    wr_data  = dt;
    step();
    wr_valid = 1'b0;
  endtask

  logic [3:0]  exp_addr [10];
  logic [31:0] exp_data [10];
  int          pushed;
  int          popped;
  bit          accepted;

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    stall = 1'b0; flush = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_ready", wr_ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_enable", enable, 0);
    chk("rst_hit_a", fwd_a_hit, 0);
    chk("rst_data_b", fwd_b_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single write
    a = 4'd5;
    push(4'd5, 32'hDEADBEEF);
    chk("single_count1", count, 1);
    chk("single_en0", enable, 0);
    chk("single_fwd_hit", fwd_a_hit, 1);
    chk("single_fwd_data", fwd_a_data, 32'hDEADBEEF);
    step();
    chk("single_en1", enable, 1);
    chk("single_c", c, 5);
    chk("single_pc", pc, 32'hDEADBEEF);
    chk("single_count0", count, 0);
    chk("single_fwd_outreg", fwd_a_data, 32'hDEADBEEF);
    step();
    chk("single_en_off", enable, 0);
    chk("single_empty", empty, 1);
    chk("single_fwd_gone", fwd_a_hit, 0);
    a = '0;

    // fill under stall
    stall = 1'b1;
    for (int k = 1; k <= 4; k++) push(4'(k), 32'h100 + 32'(k));
    chk("fill_count", count, 4);
    chk("fill_ready", wr_ready, 0);
    push(4'd9, 32'h999);
    chk("fill_ignored", count, 4);
    chk("fill_en_stalled", enable, 0);
    stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("fill_en", enable, 1);
      chk("fill_c", c, 64'(k));
      chk("fill_pc", pc, 64'(32'h100 + 32'(k)));
      chk("fill_count_drain", count, 64'(4 - k));
      chk("fill_ready_back", wr_ready, 1);
    end
    step();
    chk("fill_after", enable, 0);

    // forwarding priority
    stall = 1'b1;
    push(4'd7, 32'h11);
    push(4'd7, 32'h22);
    a = 4'd7; b = 4'd7;
    #1;
    chk("fwd_a_hit", fwd_a_hit, 1);
    chk("fwd_b_hit", fwd_b_hit, 1);
    chk("fwd_a_data", fwd_a_data, 32'h22);
    chk("fwd_b_data", fwd_b_data, 32'h22);
    stall = 1'b0;
    step();
    chk("fwd_pop_pc", pc, 32'h11);
    chk("fwd_after_pop", fwd_a_data, 32'h22);
    chk("fwd_after_pop_b", fwd_b_data, 32'h22);
    step();
    chk("fwd_outreg_data", fwd_b_data, 32'h22);
    a = 4'd8;
    #1;
    chk("fwd_miss_hit", fwd_a_hit, 0);
    chk("fwd_miss_data", fwd_a_data, 0);
    step();
    chk("fwd_drained", fwd_b_hit, 0);
    a = '0; b = '0;

    // flush with simultaneous push
    stall = 1'b1;
    push(4'd2, 32'hA);
    push(4'd3, 32'hB);
    chk("flush_pre_count", count, 2);
    flush = 1'b1; wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 32'hC;
    step();
    flush = 1'b0; wr_valid = 1'b0; stall = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_en", enable, 0);
    chk("flush_empty", empty, 1);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("flush_no_write", enable, 0);
      chk("flush_c_hold", c, 7);
      chk("flush_pc_hold", pc, 32'h22);
    end

    // wrap-around with toggling stall
    for (int i = 0; i < 10; i++) begin
      exp_addr[i] = 4'(i * 3);
      exp_data[i] = 32'h1000 + 32'(i);
    end
    pushed = 0; popped = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      stall = cyc[0];
      wr_valid = (pushed < 10);
      if (pushed < 10) begin
        wr_addr = exp_addr[pushed];
        wr_data = exp_data[pushed];
      end
      accepted = (pushed < 10) && wr_ready;
      step();
      if (accepted) pushed++;
      if (enable) begin
        if (popped < 10) begin
          chk("wrap_c", c, exp_addr[popped]);
          chk("wrap_pc", pc, exp_data[popped]);
        end else begin
          chk("wrap_extra", popped, 10);
        end
        popped++;
      end
    end
    wr_valid = 1'b0; stall = 1'b0;
    chk("wrap_pushed", pushed, 10);
    chk("wrap_popped", popped, 10);
    chk("wrap_empty", empty, 1);

    // asynchronous reset mid-drain
    stall = 1'b1;
    for (int k = 1; k <= 3; k++) push(4'(k), 32'h200 + 32'(k));
    stall = 1'b0;
    step();
    chk("arst_pre_en", enable, 1);
    chk("arst_pre_count", count, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_en", enable, 0);
    chk("arst_empty", empty, 1);
    chk("arst_ready", wr_ready, 1);
    chk("arst_c", c, 0);
    #1 rst_n = 1'b1;
    step();
    chk("arst_stays_idle", enable, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
